// File: rtl/sr_latch_trng_sequencer.sv
// sr_latch_trng_sequencer: drives one SR-latch metastability cell through excite/settle/sample,
// packs the resolved bits into words on a valid/ready port and runs a repetition-count health test.
module sr_latch_trng_sequencer #(
    parameter int WORD_BITS     = 8,
    parameter int EXCITE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int RUN_LIMIT     = 16
) (
    input  logic                 ref_clk_in,
    input  logic                 rst_in,
    input  logic                 enable_in,
    output logic                 latch_excite_out,
    input  logic                 latch_q_in,
    output logic [WORD_BITS-1:0] rnd_data_out,
    output logic                 rnd_valid_out,
    input  logic                 rnd_ready_in,
    output logic                 health_fail_out,
    input  logic                 health_clr_in,
    output logic                 busy_out
);
    localparam int CMAX = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int BW = $clog2(WORD_BITS + 1);
    localparam int RW = $clog2(RUN_LIMIT + 1);
    localparam logic [CW-1:0] EXC_LAST  = CW'(EXCITE_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(WORD_BITS - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(RUN_LIMIT);

    typedef enum logic [2:0] {IDLE, EXCITE, SETTLE, SAMPLE, PRESENT, FAULT} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [RW-1:0]        run_q, run_d, run_next;
    logic                 last_q, last_d;
    logic                 fail_q, fail_d;
    logic                 abort, sample, trip, word_done;

    // run_q == 0 marks "no previous bit", so the first bit after reset or clear starts a run of 1
    always_comb begin
        abort     = (state_q == EXCITE || state_q == SETTLE || state_q == SAMPLE) && !enable_in;
        sample    = state_q == SAMPLE && enable_in;
        run_next  = (run_q != '0 && sync2_q == last_q) ? ((run_q == RUN_MAX) ? run_q : run_q + 1'b1) : RW'(1);
        trip      = sample && run_next == RUN_MAX;
        word_done = sample && bit_q == BITS_LAST;
    end

    always_ff @(posedge ref_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            run_q   <= '0;
            last_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= latch_q_in;
            sync2_q <= sync1_q;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            run_q   <= run_d;
            last_q  <= last_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (enable_in && !fail_q) ? EXCITE : IDLE;
            EXCITE:  state_d = !enable_in ? IDLE : (cyc_q == EXC_LAST) ? SETTLE : EXCITE;
            SETTLE:  state_d = !enable_in ? IDLE : (cyc_q == SET_LAST) ? SAMPLE : SETTLE;
            SAMPLE:  state_d = !enable_in ? IDLE : trip ? FAULT : word_done ? PRESENT : EXCITE;
            PRESENT: state_d = !rnd_ready_in ? PRESENT : enable_in ? EXCITE : IDLE;
            FAULT:   state_d = health_clr_in ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
    end

    // a trip wins over a simultaneous clear so the failure is never lost
    always_comb begin
        cyc_d   = (state_d == state_q && (state_q == EXCITE || state_q == SETTLE)) ? cyc_q + 1'b1 : '0;
        bit_d   = (abort || trip || word_done) ? '0 : sample ? bit_q + 1'b1 : bit_q;
        shreg_d = (abort || trip) ? '0 : sample ? ((shreg_q << 1) | WORD_BITS'(sync2_q)) : shreg_q;
        run_d   = (health_clr_in && !trip) ? '0 : sample ? run_next : run_q;
        last_d  = sample ? sync2_q : last_q;
        fail_d  = trip || (fail_q && !health_clr_in);
    end

    always_comb begin
        latch_excite_out = state_q == EXCITE;
        rnd_valid_out    = state_q == PRESENT;
        busy_out         = state_q != IDLE;
        health_fail_out  = fail_q;
        rnd_data_out     = shreg_q;
    end
endmodule

// File: tb/tb_sr_latch_trng_sequencer.sv
// tb_sr_latch_trng_sequencer: plays the latch by presenting one chosen bit per excite pulse and
// scores every accepted word against the bits it presented, plus cycle-exact timing checks.
module tb_sr_latch_trng_sequencer;
    localparam int WB = 8, EC = 4, SC = 8, RL = 16;
    localparam int PERIOD = EC + SC + 1;
    localparam int WORD_T = WB * PERIOD;

    logic          clk = 0, rst = 1, enable = 0, latch_q = 0, ready = 0, clr = 0;
    logic          excite, valid, fail, busy;
    logic [WB-1:0] data;
    int            checks = 0, errors = 0, cyc = 0, accepts = 0;
    int            mode = 0, gen_run = 0;
    logic          alt_b = 0, gen_last = 0, ex_prev = 0, hold_v = 0, mon_b;
    logic [WB-1:0] hold_d = '0, mon_w;
    logic          drv[$];

    sr_latch_trng_sequencer #(.WORD_BITS(WB), .EXCITE_CYCLES(EC), .SETTLE_CYCLES(SC), .RUN_LIMIT(RL)) dut (
        .ref_clk_in(clk), .rst_in(rst), .enable_in(enable), .latch_excite_out(excite),
        .latch_q_in(latch_q), .rnd_data_out(data), .rnd_valid_out(valid), .rnd_ready_in(ready),
        .health_fail_out(fail), .health_clr_in(clr), .busy_out(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bit sources: 0 alternating starting at 1, 1 stuck at 1, 2 random with runs kept below RL
    task automatic next_bit(output logic b);
        if (mode == 0) begin
            alt_b = ~alt_b;
            b = alt_b;
        end else if (mode == 1) begin
            b = 1'b1;
        end else begin
            b = 1'($urandom_range(0, 1));
            if (gen_run == RL - 1 && b == gen_last) b = ~b;
            gen_run = (gen_run > 0 && b == gen_last) ? gen_run + 1 : 1;
            gen_last = b;
        end
    endtask

    function automatic logic sig(input int w);
        return w == 0 ? excite : w == 1 ? valid : w == 2 ? fail : busy;
    endfunction

    task automatic wait_sig(input int w, input logic v, input int lim, input string tag);
        int n = 0;
        while (sig(w) !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (sig(w) !== v) check({tag, "_timeout"}, sig(w), v);
    endtask

    // latch responder and word scoreboard: each accepted word must be the oldest WB presented bits
    always @(negedge clk) begin
        #1;
        if (rst) begin
            ex_prev = 0;
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("held_valid", valid, 1);
                check("held_data", data, hold_d);
            end
            if (valid) check("excite_while_valid", excite, 0);
            if (valid && ready) begin
                if (drv.size() < WB) check("scoreboard_bits", drv.size(), WB);
                else begin
                    mon_w = '0;
                    repeat (WB) mon_w = (mon_w << 1) | WB'(drv.pop_front());
                    check("word", data, mon_w);
                end
                accepts++;
            end
            hold_v = valid && !ready;
            hold_d = data;
            if (excite && !ex_prev) begin
                next_bit(mon_b);
                latch_q = mon_b;
                drv.push_back(mon_b);
            end
            ex_prev = excite;
        end
    end

    initial begin
        int t0, th, acc0, n, target;
        repeat (3) @(negedge clk);
        check("rst_excite", excite, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fail", fail, 0);
        check("rst_data", data, 0);
        rst = 0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // first word: excite shape, latency and alternating pattern
        ready = 1;
        enable = 1;
        wait_sig(0, 1, 5, "first_excite");
        t0 = cyc;
        n = 0;
        while (excite && n < 20) begin @(negedge clk); n++; end
        check("excite_high", n, EC);
        n = 0;
        while (!excite && n < 20) begin @(negedge clk); n++; end
        check("excite_low", n, SC + 1);
        wait_sig(1, 1, 200, "t2_valid");
        check("t2_latency", cyc - t0, WORD_T);
        check("t2_data", data, 8'hAA);
        th = cyc;
        @(negedge clk);
        ready = 0;
        check("t2_accepted", valid, 0);

        // backpressure
        wait_sig(1, 1, 200, "t3_valid");
        check("t3_gap", cyc - th, WORD_T + 1);
        acc0 = accepts;
        n = 0;
        repeat (50) begin @(negedge clk); if (excite) n++; end
        check("bp_no_excite", n, 0);
        check("bp_valid", valid, 1);
        check("bp_data", data, 8'hAA);
        ready = 1;
        @(negedge clk);
        check("bp_released", valid, 0);
        check("bp_one_accept", accepts - acc0, 1);

        // enable dropped during SETTLE of bit 3
        for (int k = 0; k < 4; k++) begin
            wait_sig(0, 1, 20, "t5_rise");
            wait_sig(0, 0, 20, "t5_fall");
        end
        repeat (2) @(negedge clk);
        enable = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_excite", excite, 0);
        drv.delete();
        repeat (5) @(negedge clk);
        check("abort_stays_idle", busy, 0);
        enable = 1;
        wait_sig(0, 1, 5, "t5_restart");
        t0 = cyc;
        wait_sig(1, 1, 200, "t5_valid");
        check("t5_latency", cyc - t0, WORD_T);
        @(negedge clk);

        // asynchronous reset mid-EXCITE, then stuck-at-1 health trip
        wait_sig(0, 1, 5, "t4_excite");
        #2 rst = 1;
        #1;
        check("async_rst_excite", excite, 0);
        check("async_rst_valid", valid, 0);
        check("async_rst_busy", busy, 0);
        drv.delete();
        mode = 1;
        @(negedge clk);
        rst = 0;
        wait_sig(0, 1, 5, "t4_start");
        t0 = cyc;
        wait_sig(2, 1, 400, "t4_trip");
        check("trip_time", cyc - t0, RL * PERIOD + (RL - 1) / WB);
        check("fault_valid", valid, 0);
        check("fault_busy", busy, 1);
        n = 0;
        repeat (20) begin @(negedge clk); if (excite || valid) n++; end
        check("fault_held", n, 0);
        check("fault_sticky", fail, 1);
        mode = 2;
        gen_run = 0;
        clr = 1;
        @(negedge clk);
        clr = 0;
        drv.delete();
        check("clr_fail", fail, 0);
        check("clr_idle", busy, 0);
        @(negedge clk);
        check("resume", excite, 1);

        // random bits with random consumer stalls
        th = cyc - 1;
        acc0 = accepts;
        for (int w = 0; w < 10; w++) begin
            n = 0;
            while (!valid && n < 300) begin
                @(negedge clk);
                n++;
                if (!valid) ready = 1'($urandom_range(0, 1));
            end
            if (!valid) check("rnd_valid_timeout", valid, 1);
            check("rnd_gap", cyc - th, WORD_T + 1);
            if (!ready) begin
                repeat ($urandom_range(0, 6)) @(negedge clk);
                ready = 1;
            end
            th = cyc;
            @(negedge clk);
        end
        check("rnd_no_fail", fail, 0);
        check("rnd_accepts", accepts - acc0, 10);

        // clear arriving in the same cycle as a trip
        rst = 1;
        drv.delete();
        mode = 1;
        ready = 1;
        @(negedge clk);
        rst = 0;
        wait_sig(0, 1, 5, "t7_start");
        t0 = cyc;
        target = t0 + RL * PERIOD + (RL - 1) / WB - 1;
        while (cyc < target) @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        check("clr_vs_trip_fail", fail, 1);
        check("clr_vs_trip_busy", busy, 1);
        check("clr_vs_trip_valid", valid, 0);
        clr = 1;
        @(negedge clk);
        clr = 0;
        check("late_clr_fail", fail, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
